// File: rtl/mipi_rffe_slave.sv
// RFFE slave: 2-flop synchronised sclk/sdata, SSC detect, 32x8 register file with
// Reg0 write, Register Write and Register Read. sdo updates <=3 clk after the sclk fall pin edge.
module mipi_rffe_slave #(
  parameter logic [3:0] USID     = 4'h1,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_en,
  output logic       reg_wr_vd,
  output logic [4:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RPARK  = 3'd3,
    RDATA  = 3'd4,
    RTAIL  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  sdi_sync_q, sdi_sync_d;
  logic        ssc_arm_q, ssc_arm_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] sr_q, sr_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        sdo_q, sdo_d;
  logic        sdo_en_q, sdo_en_d;
  logic        wr_vd_q, wr_vd_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        perr_q, perr_d;
  logic [7:0]  rf_q [32];
  logic [7:0]  rf_d [32];

  logic        sclk_s, sdi_s;
  logic        sclk_rise, sclk_fall, sdi_rise, sdi_fall, ssc_det;
  logic [12:0] frame;
  logic [3:0]  sa;
  logic [7:0]  cmd;
  logic [7:0]  rd_val;
  logic        sa_me, sa_bc;

  // Bit [1] is the synchronised level, bit [2] its one-clk history.
  assign sclk_sync_d = {sclk_sync_q[1:0], sclk};
  assign sdi_sync_d  = {sdi_sync_q[1:0], sdi};
  assign sclk_s      = sclk_sync_q[1];
  assign sdi_s       = sdi_sync_q[1];
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign sdi_rise    = sdi_sync_q[1] & ~sdi_sync_q[2];
  assign sdi_fall    = ~sdi_sync_q[1] & sdi_sync_q[2];
  assign ssc_det     = ssc_arm_q & sdi_fall & ~sclk_s;

  assign frame  = {sr_q, sdi_s};
  assign sa     = frame[12:9];
  assign cmd    = frame[8:1];
  assign sa_me  = (sa == USID);
  assign sa_bc  = (sa == 4'h0);
  assign rd_val = rf_q[addr_q];

  // A data-line rise only arms SSC while sclk is low; any sclk high disarms it.
  always_comb begin
    ssc_arm_d = ssc_arm_q;
    if (sclk_s) begin
      ssc_arm_d = 1'b0;
    end else if (sdi_rise) begin
      ssc_arm_d = 1'b1;
    end else if (sdi_fall) begin
      ssc_arm_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    sdo_d     = sdo_q;
    sdo_en_d  = sdo_en_q;
    wr_vd_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    perr_d    = 1'b0;
    rf_d      = rf_q;

    if (ssc_det) begin
      state_d  = CMD;
      cnt_d    = 4'd0;
      sr_d     = 12'd0;
      sdo_d    = 1'b0;
      sdo_en_d = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          if (sclk_rise) begin
            sr_d  = frame[11:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd12) begin
              state_d = IGNORE;
              cnt_d   = 4'd0;
              if (!(^frame)) begin
                perr_d = 1'b1;
              end else if (cmd[7]) begin
                if (sa_me || sa_bc) begin
                  rf_d[0]   = {1'b0, cmd[6:0]};
                  wr_vd_d   = 1'b1;
                  wr_addr_d = 5'd0;
                  wr_data_d = {1'b0, cmd[6:0]};
                end
              end else if (cmd[7:5] == 3'b010) begin
                if (sa_me || sa_bc) begin
                  addr_d  = cmd[4:0];
                  state_d = WDATA;
                end
              end else if (cmd[7:5] == 3'b011) begin
                if (sa_me) begin
                  addr_d  = cmd[4:0];
                  state_d = RPARK;
                end
              end
            end
          end
        end

        WDATA: begin
          if (sclk_rise) begin
            sr_d  = frame[11:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
              state_d = IGNORE;
              if (^frame[8:0]) begin
                rf_d[addr_q] = frame[8:1];
                wr_vd_d      = 1'b1;
                wr_addr_d    = addr_q;
                wr_data_d    = frame[8:1];
              end else begin
                perr_d = 1'b1;
              end
            end
          end
        end

        // The fall that follows the parity sample arrives before the park rise;
        // only the fall after that rise starts driving.
        RPARK: begin
          if (sclk_rise) begin
            cnt_d = 4'd1;
          end else if (sclk_fall && (cnt_q == 4'd1)) begin
            state_d  = RDATA;
            sdo_en_d = 1'b1;
            sdo_d    = rd_val[7];
            tx_d     = {rd_val[6:0], ~^rd_val};
            cnt_d    = 4'd1;
          end
        end

        // tx_q holds the remaining data bits followed by the parity bit.
        RDATA: begin
          if (sclk_fall) begin
            if (cnt_q < 4'd9) begin
              sdo_d = tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end else begin
              sdo_d   = 1'b0;
              state_d = RTAIL;
            end
          end
        end

        RTAIL: begin
          if (sclk_fall) begin
            sdo_d    = 1'b0;
            sdo_en_d = 1'b0;
            state_d  = IDLE;
          end
        end

        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 3'd0;
      sdi_sync_q  <= 3'd0;
      ssc_arm_q   <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sr_q        <= 12'd0;
      addr_q      <= 5'd0;
      tx_q        <= 8'd0;
      sdo_q       <= 1'b0;
      sdo_en_q    <= 1'b0;
      wr_vd_q     <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'd0;
      perr_q      <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= REG_INIT;
      end
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      ssc_arm_q   <= ssc_arm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      sdo_q       <= sdo_d;
      sdo_en_q    <= sdo_en_d;
      wr_vd_q     <= wr_vd_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      perr_q      <= perr_d;
      rf_q        <= rf_d;
    end
  end

  assign sdo         = sdo_q;
  assign sdo_en      = sdo_en_q;
  assign reg_wr_vd   = wr_vd_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign parity_err  = perr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mipi_rffe_slave.sv
// Directed bench for mipi_rffe_slave: bit-banged RFFE master, pad model and pulse monitors.
`timescale 1ns/1ps
module tb_mipi_rffe_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       m_drv;
  logic       m_sdi;
  logic       sdi_pad;
  logic       sdo;
  logic       sdo_en;
  logic       reg_wr_vd;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       parity_err;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int perr_cnt = 0;
  int en_cnt = 0;
  logic [4:0] last_addr = 5'd0;
  logic [7:0] last_data = 8'd0;

  mipi_rffe_slave #(.USID(4'h1), .REG_INIT(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sdi        (sdi_pad),
    .sdo        (sdo),
    .sdo_en     (sdo_en),
    .reg_wr_vd  (reg_wr_vd),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .parity_err (parity_err),
    .busy       (busy)
  );

  // Master wins when driving; otherwise the slave, else the line rests low.
  assign sdi_pad = m_drv ? m_sdi : (sdo_en ? sdo : 1'b0);

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_vd) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= reg_wr_addr;
      last_data <= reg_wr_data;
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (sdo_en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    #40 m_sdi = b;
    #40 sclk = 1'b1;
    #40 sclk = 1'b0;
  endtask

  task automatic ssc();
    m_drv = 1'b1;
    m_sdi = 1'b0;
    #40 m_sdi = 1'b1;
    #40 m_sdi = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] sa, input logic [7:0] c, input logic flip);
    logic [12:0] f;
    f = {sa, c, (~^{sa, c}) ^ flip};
    for (int i = 12; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic send_cmd(input logic [3:0] sa, input logic [7:0] c, input logic flip);
    ssc();
    send_frame(sa, c, flip);
  endtask

  task automatic send_data(input logic [7:0] d, input logic flip);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit((~^d) ^ flip);
    send_bit(1'b0);
  endtask

  task automatic rd_clocks(input int n, output logic [9:0] bits, output logic en_all);
    bits   = 10'd0;
    en_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      #75;
      bits[9-i] = sdo_en & sdo;
      en_all    = en_all & sdo_en;
      #5 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic park_then_release(output logic en_pre);
    m_sdi = 1'b0;
    #40 sclk = 1'b1;
    #35 en_pre = sdo_en;
    #5 sclk = 1'b0;
    m_drv = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] sa, input logic [4:0] a, output logic [9:0] bits,
                        output logic en_pre, output logic en_all, output logic en_post);
    send_cmd(sa, {3'b011, a}, 1'b0);
    park_then_release(en_pre);
    rd_clocks(10, bits, en_all);
    #75 en_post = sdo_en;
    #5;
  endtask

  initial begin
    logic [9:0] bits;
    logic       en_pre, en_all, en_post;
    int         w0, p0, e0;

    rst_n = 1'b0;
    sclk  = 1'b0;
    m_drv = 1'b1;
    m_sdi = 1'b0;
    #103;
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_sdo_en", 32'(sdo_en), 32'd0);
    check("rst_wr_vd", 32'(reg_wr_vd), 32'd0);
    check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #20;

    // Bus traffic without a preceding SSC must be ignored.
    send_frame(4'h1, 8'h45, 1'b0);
    send_data(8'h3C, 1'b0);
    check("nossc_busy", 32'(busy), 32'd0);
    check("nossc_wr", 32'(wr_cnt), 32'd0);

    w0 = wr_cnt; e0 = en_cnt; p0 = perr_cnt;
    send_cmd(4'h1, 8'h45, 1'b0);
    send_data(8'hA5, 1'b0);
    check("wr5_count", 32'(wr_cnt - w0), 32'd1);
    check("wr5_addr", 32'(last_addr), 32'd5);
    check("wr5_data", 32'(last_data), 32'hA5);
    check("wr5_no_en", 32'(en_cnt - e0), 32'd0);
    check("wr5_no_perr", 32'(perr_cnt - p0), 32'd0);
    check("wr5_busy", 32'(busy), 32'd1);

    rd_reg(4'h1, 5'd5, bits, en_pre, en_all, en_post);
    check("rd5_en_pre", 32'(en_pre), 32'd0);
    check("rd5_bits", 32'(bits), 32'({8'hA5, 1'b1, 1'b0}));
    check("rd5_en_all", 32'(en_all), 32'd1);
    check("rd5_en_post", 32'(en_post), 32'd0);
    check("rd5_busy", 32'(busy), 32'd0);

    w0 = wr_cnt;
    send_cmd(4'h0, 8'hFF, 1'b0);
    send_bit(1'b0);
    check("bc0_count", 32'(wr_cnt - w0), 32'd1);
    check("bc0_addr", 32'(last_addr), 32'd0);
    check("bc0_data", 32'(last_data), 32'h7F);
    rd_reg(4'h1, 5'd0, bits, en_pre, en_all, en_post);
    check("rd0_bits", 32'(bits), 32'({8'h7F, 1'b0, 1'b0}));

    w0 = wr_cnt; p0 = perr_cnt;
    send_cmd(4'h1, 8'h45, 1'b1);
    send_data(8'h3C, 1'b0);
    check("cpar_perr", 32'(perr_cnt - p0), 32'd1);
    check("cpar_no_wr", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt; p0 = perr_cnt;
    send_cmd(4'h1, 8'h45, 1'b0);
    send_data(8'h3C, 1'b1);
    check("dpar_perr", 32'(perr_cnt - p0), 32'd1);
    check("dpar_no_wr", 32'(wr_cnt - w0), 32'd0);
    rd_reg(4'h1, 5'd5, bits, en_pre, en_all, en_post);
    check("par_keep5", 32'(bits), 32'({8'hA5, 1'b1, 1'b0}));

    // Broadcast read and foreign-SA read are both ignored.
    e0 = en_cnt;
    rd_reg(4'h0, 5'd5, bits, en_pre, en_all, en_post);
    check("bcrd_no_en", 32'(en_cnt - e0), 32'd0);
    rd_reg(4'h2, 5'd5, bits, en_pre, en_all, en_post);
    check("sa2_no_en", 32'(en_cnt - e0), 32'd0);
    check("sa2_bits", 32'(bits), 32'd0);
    check("sa2_busy", 32'(busy), 32'd1);

    // SSC injected after four RDATA bits.
    send_cmd(4'h1, {3'b011, 5'd5}, 1'b0);
    park_then_release(en_pre);
    rd_clocks(4, bits, en_all);
    check("abort_bits", 32'(bits[9:6]), 32'hA);
    check("abort_en_before", 32'(en_all), 32'd1);
    #60 m_drv = 1'b1;
    m_sdi = 1'b0;
    #20 m_sdi = 1'b1;
    #20 m_sdi = 1'b0;
    #48 check("abort_en_off", 32'(sdo_en), 32'd0);
    #32;
    w0 = wr_cnt;
    send_frame(4'h1, 8'h43, 1'b0);
    send_data(8'h5A, 1'b0);
    check("abort_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("abort_wr_addr", 32'(last_addr), 32'd3);
    check("abort_wr_data", 32'(last_data), 32'h5A);
    rd_reg(4'h1, 5'd3, bits, en_pre, en_all, en_post);
    check("rd3_bits", 32'(bits), 32'({8'h5A, 1'b1, 1'b0}));

    // Reset during a read drops sdo_en at once and restores REG_INIT.
    send_cmd(4'h1, {3'b011, 5'd5}, 1'b0);
    park_then_release(en_pre);
    rd_clocks(2, bits, en_all);
    check("rstrd_en_before", 32'(sdo_en), 32'd1);
    rst_n = 1'b0;
    #1 check("rstrd_en_off", 32'(sdo_en), 32'd0);
    #19 rst_n = 1'b1;
    rd_reg(4'h1, 5'd5, bits, en_pre, en_all, en_post);
    check("rstrd_init", 32'(bits), 32'({8'h00, 1'b1, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
